cr_su_req_arb: RTL and testbench

// - Round-robin arbiter ahead of the schedule-update (SU) core input. Merges N_REQ engine

---
 rtl/cr_su_req_arb.sv | 147 ++++++++++++++
 tb/tb_cr_su_req_arb.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/cr_su_req_arb.sv
// Round-robin arbiter merging N_REQ engine request streams into the SU core input.
// Optional per-requester burst statistics enabled by macro CR_SU_REQ_ARB_STATS_EN.
module cr_su_req_arb #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned DATA_W = 64,
  localparam int unsigned PTR_W = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ-1:0]        req_last,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ-1:0]        arb_mask,
  input  logic                    su_ready,
  output logic                    su_in_valid,
  output logic [DATA_W-1:0]       su_in_data,
  output logic                    su_in_last,
  output logic [PTR_W-1:0]        su_in_src,
  input  logic                    stat_clr,
  output logic [N_REQ*32-1:0]     stat_bursts
);

  localparam int unsigned STAT_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   grant_idx;
  logic [PTR_W-1:0]   grant_nxt;
  logic [PTR_W-1:0]   sel;
  logic [PTR_W-1:0]   acc_idx;
  logic [N_REQ-1:0]   eligible;
  logic               out_free;
  logic               acc;
  logic               acc_last;
  logic [DATA_W-1:0]  data_arr [N_REQ];

  // First eligible requester at or after ptr, searching cyclically.
  function automatic logic [PTR_W-1:0] rr_pick(input logic [N_REQ-1:0] elig,
                                               input logic [PTR_W-1:0] ptr);
    logic [PTR_W-1:0] pick;
    int unsigned      idx;
    pick = ptr;
    for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
      idx = (32'(ptr) + 32'(i)) % N_REQ;
      if (elig[PTR_W'(idx)]) pick = PTR_W'(idx);
    end
    return pick;
  endfunction

  for (genvar i = 0; i < int'(N_REQ); i++) begin : g_data
    assign data_arr[i] = req_data[i*DATA_W +: DATA_W];
  end

  assign out_free = !su_in_valid || su_ready;
  assign eligible = req_valid & ~arb_mask;
  assign sel      = rr_pick(eligible, rr_ptr);
  assign acc_last = acc && req_last[acc_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      grant_idx <= '0;
    end else begin
      state     <= state_nxt;
      grant_idx <= grant_nxt;
    end
  end

  // Grant selection and beat acceptance; a granted burst holds until its last beat.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant_idx;
    req_ready = '0;
    acc       = 1'b0;
    acc_idx   = grant_idx;
    case (state)
      IDLE: begin
        if (out_free && (eligible != '0)) begin
          req_ready[sel] = 1'b1;
          acc            = 1'b1;
          acc_idx        = sel;
          grant_nxt      = sel;
          if (!req_last[sel]) state_nxt = LOCK;
        end
      end
      LOCK: begin
        req_ready[grant_idx] = out_free;
        acc                  = out_free && req_valid[grant_idx];
        if (acc && req_last[grant_idx]) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (acc_last) begin
      rr_ptr <= (acc_idx == PTR_W'(N_REQ - 1)) ? '0 : acc_idx + PTR_W'(1);
    end
  end

  // One-entry output register; holds while full and stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      su_in_valid <= 1'b0;
      su_in_data  <= '0;
      su_in_last  <= 1'b0;
      su_in_src   <= '0;
    end else if (out_free) begin
      su_in_valid <= acc;
      if (acc) begin
        su_in_data <= data_arr[acc_idx];
        su_in_last <= req_last[acc_idx];
        su_in_src  <= acc_idx;
      end
    end
  end

`ifdef CR_SU_REQ_ARB_STATS_EN
  for (genvar i = 0; i < int'(N_REQ); i++) begin : g_stat
    logic [STAT_W-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt <= '0;
      end else if (stat_clr) begin
        cnt <= '0;
      end else if (acc_last && (acc_idx == PTR_W'(i)) && (cnt != '1)) begin
        cnt <= cnt + STAT_W'(1);
      end
    end
    assign stat_bursts[i*STAT_W +: STAT_W] = cnt;
  end
`else
  logic unused_stat_clr;
  assign unused_stat_clr = stat_clr;
  assign stat_bursts     = '0;
`endif

endmodule

// File: tb/tb_cr_su_req_arb.sv
// Directed self-checking bench for cr_su_req_arb (N_REQ=4, DATA_W=64).
module tb_cr_su_req_arb;

  localparam int unsigned N_REQ  = 4;
  localparam int unsigned DATA_W = 64;

  logic                    clk;
  logic                    rst_n;
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_last;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ-1:0]        arb_mask;
  logic                    su_ready;
  logic                    su_in_valid;
  logic [DATA_W-1:0]       su_in_data;
  logic                    su_in_last;
  logic [1:0]              su_in_src;
  logic                    stat_clr;
  logic [N_REQ*32-1:0]     stat_bursts;

  int n_tests = 0;
  int n_fail  = 0;

  cr_su_req_arb #(.N_REQ(N_REQ), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .arb_mask(arb_mask), .su_ready(su_ready),
    .su_in_valid(su_in_valid), .su_in_data(su_in_data), .su_in_last(su_in_last),
    .su_in_src(su_in_src), .stat_clr(stat_clr), .stat_bursts(stat_bursts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input int i, input logic v, input logic l, input logic [63:0] d);
    req_valid[i] = v;
    req_last[i]  = l;
    req_data[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic exp_rdy(input string tag, input logic [3:0] exp);
    #1;
    chk(tag, 128'(req_ready), 128'(exp));
  endtask

  task automatic exp_out(input string tag, input logic [1:0] src, input logic [63:0] d,
                         input logic l);
    cyc();
    chk({tag, "_v"}, 128'(su_in_valid), 128'(1'b1));
    chk({tag, "_src"}, 128'(su_in_src), 128'(src));
    chk({tag, "_data"}, 128'(su_in_data), 128'(d));
    chk({tag, "_last"}, 128'(su_in_last), 128'(l));
  endtask

  task automatic exp_drain(input string tag);
    cyc();
    chk(tag, 128'(su_in_valid), 128'(1'b0));
  endtask

  logic [127:0] stat_exp;
  logic [1:0]   seq1 [5];

  initial begin
    rst_n = 1'b0; req_valid = '0; req_data = '0; req_last = '0;
    arb_mask = '0; su_ready = 1'b0; stat_clr = 1'b0;
    seq1[0] = 2'd0; seq1[1] = 2'd1; seq1[2] = 2'd2; seq1[3] = 2'd3; seq1[4] = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 128'(su_in_valid), 128'(1'b0));
    chk("rst_src", 128'(su_in_src), 128'(2'd0));
    chk("rst_data", 128'(su_in_data), 128'(64'd0));
    chk("rst_ready", 128'(req_ready), 128'(4'b0000));
    chk("rst_stat", stat_bursts, 128'd0);
    rst_n = 1'b1;

    // All four 1-beat valid: round robin 0,1,2,3,0
    su_ready = 1'b1;
    for (int i = 0; i < 4; i++) set_beat(i, 1'b1, 1'b1, 64'h100 + 64'(i));
    for (int k = 0; k < 5; k++) begin
      exp_rdy("t1_rdy", 4'b0001 << seq1[k]);
      exp_out("t1_out", seq1[k], 64'h100 + 64'(seq1[k]), 1'b1);
    end
    req_valid = '0;
    exp_rdy("t1_idle_rdy", 4'b0000);
    exp_drain("t1_drain");

    // Req1 3-beat burst with req2 waiting (rr_ptr=1)
    set_beat(1, 1'b1, 1'b0, 64'h110);
    set_beat(2, 1'b1, 1'b1, 64'h220);
    exp_rdy("t2_b0_rdy", 4'b0010);
    exp_out("t2_b0", 2'd1, 64'h110, 1'b0);
    set_beat(1, 1'b1, 1'b0, 64'h111);
    exp_rdy("t2_b1_rdy", 4'b0010);
    exp_out("t2_b1", 2'd1, 64'h111, 1'b0);
    set_beat(1, 1'b1, 1'b1, 64'h112);
    exp_rdy("t2_b2_rdy", 4'b0010);
    exp_out("t2_b2", 2'd1, 64'h112, 1'b1);
    set_beat(1, 1'b1, 1'b1, 64'h113);
    exp_rdy("t2_ptr2_rdy", 4'b0100);
    exp_out("t2_req2", 2'd2, 64'h220, 1'b1);
    req_valid = '0;
    exp_drain("t2_drain");

    // Backpressure: output full for 5 cycles (rr_ptr=3)
    set_beat(0, 1'b1, 1'b1, 64'hA0);
    exp_rdy("t3_rdy", 4'b0001);
    exp_out("t3_a0", 2'd0, 64'hA0, 1'b1);
    set_beat(0, 1'b1, 1'b1, 64'hA1);
    su_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      exp_rdy("t3_stall_rdy", 4'b0000);
      cyc();
      chk("t3_hold_v", 128'(su_in_valid), 128'(1'b1));
      chk("t3_hold_data", 128'(su_in_data), 128'(64'hA0));
    end
    su_ready = 1'b1;
    exp_rdy("t3_rel_rdy", 4'b0001);
    exp_out("t3_a1", 2'd0, 64'hA1, 1'b1);
    req_valid = '0;
    exp_drain("t3_drain");

    // Mask req1 during its lock, plus a mid-burst valid gap (rr_ptr=1)
    set_beat(1, 1'b1, 1'b0, 64'hB0);
    exp_rdy("t4_b0_rdy", 4'b0010);
    exp_out("t4_b0", 2'd1, 64'hB0, 1'b0);
    arb_mask = 4'b0010;
    set_beat(1, 1'b1, 1'b0, 64'hB1);
    exp_rdy("t4_b1_rdy", 4'b0010);
    exp_out("t4_b1", 2'd1, 64'hB1, 1'b0);
    set_beat(1, 1'b0, 1'b0, 64'hB1);
    set_beat(0, 1'b1, 1'b1, 64'hC0);
    exp_rdy("t4_gap_rdy", 4'b0010);
    exp_drain("t4_gap");
    set_beat(1, 1'b1, 1'b1, 64'hB2);
    exp_rdy("t4_b2_rdy", 4'b0010);
    exp_out("t4_b2", 2'd1, 64'hB2, 1'b1);
    exp_rdy("t4_mask_rdy0", 4'b0001);
    exp_out("t4_c0", 2'd0, 64'hC0, 1'b1);
    exp_rdy("t4_mask_rdy1", 4'b0001);
    exp_out("t4_c0b", 2'd0, 64'hC0, 1'b1);
    req_valid = '0;
    arb_mask  = '0;
    exp_drain("t4_drain");

    // Req3 bursts, pointer wraps to 0; statistics (rr_ptr=1)
    stat_clr = 1'b1;
    cyc();
    stat_clr = 1'b0;
    chk("t5_clr0", stat_bursts, 128'd0);
    for (int b = 0; b < 2; b++) begin
      set_beat(3, 1'b1, 1'b0, 64'hD0 + 64'(2*b));
      exp_rdy("t5_d_rdy", 4'b1000);
      exp_out("t5_d_first", 2'd3, 64'hD0 + 64'(2*b), 1'b0);
      set_beat(3, 1'b1, 1'b1, 64'hD1 + 64'(2*b));
      exp_rdy("t5_d_rdy", 4'b1000);
      exp_out("t5_d_last", 2'd3, 64'hD1 + 64'(2*b), 1'b1);
    end
    set_beat(0, 1'b1, 1'b1, 64'hE0);
    exp_rdy("t5_wrap_rdy", 4'b0001);
    exp_out("t5_e0", 2'd0, 64'hE0, 1'b1);
`ifdef CR_SU_REQ_ARB_STATS_EN
    stat_exp = {32'd2, 32'd0, 32'd0, 32'd1};
`else
    stat_exp = 128'd0;
`endif
    chk("t5_stat", stat_bursts, stat_exp);
    set_beat(0, 1'b0, 1'b1, 64'hE0);
    set_beat(3, 1'b1, 1'b1, 64'hF0);
    stat_clr = 1'b1;
    exp_rdy("t5_clrwin_rdy", 4'b1000);
    exp_out("t5_f0", 2'd3, 64'hF0, 1'b1);
    chk("t5_clr_wins", stat_bursts, 128'd0);
    stat_clr  = 1'b0;
    req_valid = '0;
    exp_drain("t5_drain");

    // Reset mid-burst (rr_ptr=0)
    set_beat(0, 1'b1, 1'b1, 64'h10);
    exp_rdy("t6_pre_rdy", 4'b0001);
    exp_out("t6_pre", 2'd0, 64'h10, 1'b1);
    req_valid = '0;
    set_beat(2, 1'b1, 1'b0, 64'h20);
    exp_rdy("t6_b0_rdy", 4'b0100);
    exp_out("t6_b0", 2'd2, 64'h20, 1'b0);
    req_valid = '0;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 128'(su_in_valid), 128'(1'b0));
    chk("t6_rst_src", 128'(su_in_src), 128'(2'd0));
    chk("t6_rst_rdy", 128'(req_ready), 128'(4'b0000));
    cyc();
    rst_n = 1'b1;
    set_beat(0, 1'b1, 1'b1, 64'h30);
    set_beat(2, 1'b1, 1'b1, 64'h40);
    exp_rdy("t6_post_rdy", 4'b0001);
    exp_out("t6_post", 2'd0, 64'h30, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
